// File: rtl/i2c_txshift.sv
// I2C transmit byte engine: pops TX FIFO bytes, serialises them MSB-first to the
// bit controller and samples the ACK slot. Optional tx_cnt counter: I2C_TXSHIFT_CNT_EN.
module i2c_txshift #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_do,
   output logic                  fifo_rd_n,
   output logic                  bit_req,
   output logic                  bit_sda,
   input  logic                  bit_ack,
   input  logic                  bit_din,
   output logic                  busy,
   output logic                  done,
   output logic                  nack,
   output logic [CNT_BITS-1:0]   tx_cnt
);

   localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_ACK   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [BC_W-1:0]       r_bitcnt;
   logic                  r_nack;
   logic                  w_accept;
   logic                  w_ack_slot;

   // abort blocks every transition, including a start arriving in IDLE
   assign w_accept   = (r_state == S_IDLE) && start && !abort;
   assign w_ack_slot = (r_state == S_ACK) && bit_ack && !abort;

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_next = fifo_empty ? S_DONE : S_FETCH;
            S_FETCH: w_next = S_SHIFT;
            S_SHIFT: if (bit_ack && (r_bitcnt == '0)) w_next = S_ACK;
            S_ACK:   if (bit_ack) w_next = (bit_din || fifo_empty) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg  <= '0;
         r_bitcnt <= '0;
      end else if (!abort) begin
         if (r_state == S_FETCH) begin
            r_shreg  <= fifo_do;
            r_bitcnt <= BC_LAST;
         end else if ((r_state == S_SHIFT) && bit_ack) begin
            r_shreg  <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
            if (r_bitcnt != '0) r_bitcnt <= r_bitcnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_nack <= 1'b0;
      else if (w_accept)              r_nack <= 1'b0;
      else if (w_ack_slot && bit_din) r_nack <= 1'b1;
   end

`ifdef I2C_TXSHIFT_CNT_EN
   logic [CNT_BITS-1:0] r_tx_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_tx_cnt <= '0;
      else if (w_accept)
         r_tx_cnt <= '0;
      else if (w_ack_slot && !bit_din && (r_tx_cnt != '1))
         r_tx_cnt <= r_tx_cnt + 1'b1;
   end

   assign tx_cnt = r_tx_cnt;
`else
   assign tx_cnt = '0;
`endif

   // every output is a pure decode of registered state
   assign fifo_rd_n = (r_state != S_FETCH);
   assign bit_req   = (r_state == S_SHIFT) || (r_state == S_ACK);
   assign bit_sda   = (r_state == S_SHIFT) ? r_shreg[DATA_WIDTH-1] : 1'b1;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign nack      = r_nack;

endmodule

// File: tb/tb_i2c_txshift.sv
// Directed self-checking bench for i2c_txshift with a pointer-based TX FIFO model
// and a bit-controller responder acknowledging every fourth cycle.
module tb_i2c_txshift;

`ifdef I2C_TXSHIFT_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_do;
   logic       fifo_rd_n;
   logic       bit_req;
   logic       bit_sda;
   logic       bit_ack = 1'b0;
   logic       bit_din = 1'b0;
   logic       busy;
   logic       done;
   logic       nack;
   logic [3:0] tx_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [64];
   logic [5:0] wr_ptr = '0;
   logic [5:0] rd_ptr = '0;

   int rd_cnt = 0, done_cnt = 0, req_cnt = 0, gap_cnt = 0, ack_sent = 0;

   i2c_txshift #(.DATA_WIDTH(8), .CNT_BITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .fifo_empty(fifo_empty), .fifo_do(fifo_do), .fifo_rd_n(fifo_rd_n),
      .bit_req(bit_req), .bit_sda(bit_sda), .bit_ack(bit_ack), .bit_din(bit_din),
      .busy(busy), .done(done), .nack(nack), .tx_cnt(tx_cnt)
   );

   always #5 clk = ~clk;

   assign fifo_do    = mem[rd_ptr];
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) if (!fifo_rd_n) rd_ptr <= rd_ptr + 6'd1;

   // per-cycle activity counters, sampled on the edge that ends each cycle
   always @(posedge clk) begin
      if (!fifo_rd_n)         rd_cnt   <= rd_cnt + 1;
      if (done)               done_cnt <= done_cnt + 1;
      if (bit_req)            req_cnt  <= req_cnt + 1;
      if (busy && !bit_req)   gap_cnt  <= gap_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 6'd1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_bit(input logic din, output logic sda);
      int n;
      repeat (3) @(negedge clk);
      n = 0;
      while (!bit_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bit_req_wait", bit_req, 1'b1);
      sda     = bit_sda;
      bit_din = din;
      bit_ack = 1'b1;
      @(negedge clk);
      bit_ack = 1'b0;
      bit_din = 1'b0;
      ack_sent++;
   endtask

   task automatic send_byte(input logic [7:0] exp, input logic ack_din);
      logic [7:0] got;
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b0, s);
         got[i] = s;
      end
      check("byte_bits", got, exp);
      send_bit(ack_din, s);
      check("ack_slot_sda", s, 1'b1);
   endtask

   initial begin
      int rd0, dn0, rq0, gp0, ak0;
      logic [2:0] b3;
      logic s;

      // reset state
      #1;
      check("rst_rd_n", fifo_rd_n, 1'b1);
      check("rst_req",  bit_req,   1'b0);
      check("rst_sda",  bit_sda,   1'b1);
      check("rst_busy", busy,      1'b0);
      check("rst_done", done,      1'b0);
      check("rst_nack", nack,      1'b0);
      check("rst_cnt",  tx_cnt,    4'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single byte 0xA5, ACKed; start latency
      push(8'hA5);
      rd0 = rd_cnt; dn0 = done_cnt; gp0 = gap_cnt;
      pulse_start();
      check("t1_fetch_rd_n", fifo_rd_n, 1'b0);
      check("t1_fetch_busy", busy, 1'b1);
      check("t1_fetch_req",  bit_req, 1'b0);
      @(negedge clk);
      check("t1_shift_req", bit_req, 1'b1);
      check("t1_shift_msb", bit_sda, 1'b1);
      send_byte(8'hA5, 1'b0);
      check("t1_done_now", done, 1'b1);
      repeat (2) @(negedge clk);
      check("t1_rd_pulses", rd_cnt - rd0, 1);
      check("t1_done_cnt",  done_cnt - dn0, 1);
      check("t1_gap",       gap_cnt - gp0, 2);
      check("t1_nack",      nack, 1'b0);
      check("t1_tx_cnt",    tx_cnt, CNT_ON ? 4'd1 : 4'd0);

      // two bytes 0x3C, 0xFF, both ACKed
      push(8'h3C); push(8'hFF);
      rd0 = rd_cnt; dn0 = done_cnt; gp0 = gap_cnt; ak0 = ack_sent;
      pulse_start();
      send_byte(8'h3C, 1'b0);
      check("t2_gap_fetch_req", bit_req, 1'b0);
      check("t2_gap_fetch_rd",  fifo_rd_n, 1'b0);
      send_byte(8'hFF, 1'b0);
      repeat (2) @(negedge clk);
      check("t2_rd_pulses", rd_cnt - rd0, 2);
      check("t2_acks",      ack_sent - ak0, 18);
      check("t2_gap",       gap_cnt - gp0, 3);
      check("t2_done_cnt",  done_cnt - dn0, 1);
      check("t2_tx_cnt",    tx_cnt, CNT_ON ? 4'd2 : 4'd0);

      // NACK on first byte of {0x12, 0x34}
      push(8'h12); push(8'h34);
      rd0 = rd_cnt; dn0 = done_cnt;
      pulse_start();
      send_byte(8'h12, 1'b1);
      repeat (2) @(negedge clk);
      check("t3_nack",      nack, 1'b1);
      check("t3_tx_cnt",    tx_cnt, 4'd0);
      check("t3_done_cnt",  done_cnt - dn0, 1);
      check("t3_rd_pulses", rd_cnt - rd0, 1);
      check("t3_fifo_left", fifo_empty, 1'b0);
      check("t3_fifo_head", fifo_do, 8'h34);

      // reset mid-SHIFT of the second byte of {0x34, 0x99}
      push(8'h99);
      pulse_start();
      check("t4_nack_cleared", nack, 1'b0);
      send_byte(8'h34, 1'b0);
      send_bit(1'b0, s);
      check("t4_bit0", s, 1'b1);
      send_bit(1'b0, s);
      check("t4_bit1", s, 1'b0);
      check("t4_pre_cnt", tx_cnt, CNT_ON ? 4'd1 : 4'd0);
      check("t4_pre_req", bit_req, 1'b1);
      rst = 1'b1;
      #1;
      check("t4_rst_rd_n", fifo_rd_n, 1'b1);
      check("t4_rst_req",  bit_req,   1'b0);
      check("t4_rst_sda",  bit_sda,   1'b1);
      check("t4_rst_busy", busy,      1'b0);
      check("t4_rst_done", done,      1'b0);
      check("t4_rst_nack", nack,      1'b0);
      check("t4_rst_cnt",  tx_cnt,    4'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 17 ACKed bytes: counter saturates at 15
      for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
      rd0 = rd_cnt; dn0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 17; i++) send_byte(8'(8'h40 + i), 1'b0);
      repeat (2) @(negedge clk);
      check("t5_rd_pulses", rd_cnt - rd0, 17);
      check("t5_done_cnt",  done_cnt - dn0, 1);
      check("t5_tx_cnt",    tx_cnt, CNT_ON ? 4'd15 : 4'd0);
      check("t5_empty",     fifo_empty, 1'b1);

      // start with empty FIFO
      rd0 = rd_cnt; rq0 = req_cnt;
      pulse_start();
      check("t6_done",  done, 1'b1);
      check("t6_busy",  busy, 1'b1);
      check("t6_req",   bit_req, 1'b0);
      @(negedge clk);
      check("t6_done_end", done, 1'b0);
      check("t6_busy_end", busy, 1'b0);
      check("t6_rd_pulses", rd_cnt - rd0, 0);
      check("t6_req_cycles", req_cnt - rq0, 0);
      check("t6_tx_cnt", tx_cnt, 4'd0);

      // abort after 3 bits of 0xF0, then a clean 0x55 burst
      push(8'hF0);
      rd0 = rd_cnt; dn0 = done_cnt;
      pulse_start();
      for (int i = 2; i >= 0; i--) begin
         send_bit(1'b0, s);
         b3[i] = s;
      end
      check("t7_first3", b3, 3'b111);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t7_req_off",  bit_req, 1'b0);
      check("t7_busy_off", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("t7_done_cnt",  done_cnt - dn0, 0);
      check("t7_rd_pulses", rd_cnt - rd0, 1);
      push(8'h55);
      dn0 = done_cnt;
      pulse_start();
      send_byte(8'h55, 1'b0);
      repeat (2) @(negedge clk);
      check("t7_done_cnt2", done_cnt - dn0, 1);
      check("t7_nack",      nack, 1'b0);
      check("t7_tx_cnt",    tx_cnt, CNT_ON ? 4'd1 : 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
